// File: rtl/shift_counter_gen_if.sv
// Control and status bundle for shift_counter_gen.
// master drives en/dir/mode/load/load_val; slave returns out/phase/wrap/err.
interface shift_counter_gen_if #(
  parameter int WIDTH = 4
);
  localparam int PW = $clog2(2*WIDTH);

  logic             en;
  logic             dir;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic [PW-1:0]    phase;
  logic             wrap;
  logic             err;

  modport master (
    output en, dir, mode, load, load_val,
    input  out, phase, wrap, err
  );

  modport slave (
    input  en, dir, mode, load, load_val,
    output out, phase, wrap, err
  );
endinterface

// File: rtl/shift_counter_gen.sv
// Johnson / one-hot ring shift counter with load, phase decode,
// wrap pulse and illegal-state correction. Ports: clk, reset (sync, low), bus.
module shift_counter_gen #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic reset,
  shift_counter_gen_if.slave bus
);
  localparam int PW = $clog2(2*WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [PW:0]      dec_v;
  logic             cur_ok;
  logic [PW-1:0]    cur_ph;

  function automatic logic [WIDTH-1:0] rst_val(
    input logic m
  );
    return m ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
  endfunction

  // {legal, phase}; phase is zero for illegal states
  function automatic logic [PW:0] dec(
    input logic [WIDTH-1:0] v,
    input logic             m
  );
    logic          ok;
    logic [PW-1:0] ph;
    ok = 1'b0;
    ph = '0;
    if (!m) begin
      for (int k = 0; k <= WIDTH; k++) begin
        if (v == ~(ONES >> k)) begin
          ok = 1'b1;
          ph = PW'(k);
        end
      end
      for (int j = 1; j < WIDTH; j++) begin
        if (v == (ONES >> j)) begin
          ok = 1'b1;
          ph = PW'(WIDTH + j);
        end
      end
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (v == (ONE << (WIDTH-1-k))) begin
          ok = 1'b1;
          ph = PW'(k);
        end
      end
    end
    return {ok, ph};
  endfunction

  function automatic logic [WIDTH-1:0] nxt(
    input logic [WIDTH-1:0] v,
    input logic             m,
    input logic             d
  );
    logic [WIDTH-1:0] r;
    unique case ({m, d})
      2'b00: r = {~v[0], v[WIDTH-1:1]};
      2'b01: r = {v[WIDTH-2:0], ~v[WIDTH-1]};
      2'b10: r = {v[0], v[WIDTH-1:1]};
      default: r = {v[WIDTH-2:0], v[WIDTH-1]};
    endcase
    return r;
  endfunction

  assign dec_v  = dec(out_q, mode_q);
  assign cur_ok = dec_v[PW];
  assign cur_ph = dec_v[PW-1:0];

  always_comb begin
    out_d  = out_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (bus.mode != mode_q) begin
      out_d  = rst_val(bus.mode);
      mode_d = bus.mode;
    end else if (bus.load) begin
      out_d = bus.load_val;
    end else if (!cur_ok) begin
      out_d = rst_val(mode_q);
      err_d = 1'b1;
    end else if (bus.en) begin
      out_d = nxt(out_q, mode_q, bus.dir);
      if (bus.dir)
        wrap_d = (cur_ph == '0);
      else if (mode_q)
        wrap_d = (cur_ph == PW'(WIDTH-1));
      else
        wrap_d = (cur_ph == PW'(2*WIDTH-1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q  <= rst_val(bus.mode);
      mode_q <= bus.mode;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.phase = cur_ph;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_shift_counter_gen.sv
// Directed vector bench for shift_counter_gen, WIDTH=4.
// Table rows give inputs for one edge and outputs expected after it.
module tb_shift_counter_gen;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;

  shift_counter_gen_if #(.WIDTH(4)) bus();

  shift_counter_gen #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic       dir;
    logic       mode;
    logic       load;
    logic [3:0] lv;
    logic [3:0] e_out;
    logic [2:0] e_ph;
    logic       e_wrap;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic v(
    input string nm,
    input logic r, input logic e, input logic d,
    input logic m, input logic l, input logic [3:0] lv,
    input logic [3:0] o, input logic [2:0] p,
    input logic w, input logic er
  );
    vec_t x;
    x.name = nm; x.rst = r; x.en = e; x.dir = d;
    x.mode = m; x.load = l; x.lv = lv;
    x.e_out = o; x.e_ph = p; x.e_wrap = w; x.e_err = er;
    tbl.push_back(x);
  endtask

  task automatic chk(
    input string nm,
    input logic [8:0] act,
    input logic [8:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: act out=%b ph=%0d w=%b e=%b exp out=%b ph=%0d w=%b e=%b",
        nm, act[8:5], act[4:2], act[1], act[0],
        exp[8:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [8:0] obs();
    return {bus.out, bus.phase, bus.wrap, bus.err};
  endfunction

  task automatic drive(
    input logic r, input logic e, input logic d,
    input logic m, input logic l, input logic [3:0] lv
  );
    reset = r; bus.en = e; bus.dir = d;
    bus.mode = m; bus.load = l; bus.load_val = lv;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 4'b0000);
    // reset and Johnson up
    v("rst",   0,0,0,0,0,4'h0, 4'b0000,0,0,0);
    v("ju1",   1,1,0,0,0,4'h0, 4'b1000,1,0,0);
    v("ju2",   1,1,0,0,0,4'h0, 4'b1100,2,0,0);
    v("ju3",   1,1,0,0,0,4'h0, 4'b1110,3,0,0);
    v("ju4",   1,1,0,0,0,4'h0, 4'b1111,4,0,0);
    v("ju5",   1,1,0,0,0,4'h0, 4'b0111,5,0,0);
    v("ju6",   1,1,0,0,0,4'h0, 4'b0011,6,0,0);
    v("ju7",   1,1,0,0,0,4'h0, 4'b0001,7,0,0);
    v("juwrap",1,1,0,0,0,4'h0, 4'b0000,0,1,0);
    // Johnson down
    v("jdwrap",1,1,1,0,0,4'h0, 4'b0001,7,1,0);
    v("jd6",   1,1,1,0,0,4'h0, 4'b0011,6,0,0);
    v("jd5",   1,1,1,0,0,4'h0, 4'b0111,5,0,0);
    v("jd4",   1,1,1,0,0,4'h0, 4'b1111,4,0,0);
    v("jd3",   1,1,1,0,0,4'h0, 4'b1110,3,0,0);
    v("jd2",   1,1,1,0,0,4'h0, 4'b1100,2,0,0);
    v("jd1",   1,1,1,0,0,4'h0, 4'b1000,1,0,0);
    v("jd0",   1,1,1,0,0,4'h0, 4'b0000,0,0,0);
    // to 1100, then switch to ring
    v("j1",    1,1,0,0,0,4'h0, 4'b1000,1,0,0);
    v("j2",    1,1,0,0,0,4'h0, 4'b1100,2,0,0);
    v("tomode1",1,1,0,1,0,4'h0,4'b1000,0,0,0);
    v("ru1",   1,1,0,1,0,4'h0, 4'b0100,1,0,0);
    v("ru2",   1,1,0,1,0,4'h0, 4'b0010,2,0,0);
    v("ru3",   1,1,0,1,0,4'h0, 4'b0001,3,0,0);
    v("ruwrap",1,1,0,1,0,4'h0, 4'b1000,0,1,0);
    v("tomode0",1,1,0,0,0,4'h0,4'b0000,0,0,0);
    // illegal load and correction
    v("ldbad", 1,1,0,0,1,4'b1010, 4'b1010,0,0,0);
    v("fix",   1,1,0,0,0,4'h0, 4'b0000,0,0,1);
    v("resume",1,1,0,0,0,4'h0, 4'b1000,1,0,0);
    v("ldbad2",1,1,0,0,1,4'b1010, 4'b1010,0,0,0);
    v("ldpre", 1,1,0,0,1,4'b0111, 4'b0111,5,0,0);
    v("r_mode",1,0,0,1,0,4'h0, 4'b1000,0,0,0);
    v("r_ld0", 1,0,0,1,1,4'b0000, 4'b0000,0,0,0);
    v("r_fix", 1,0,0,1,0,4'h0, 4'b1000,0,0,1);
    v("r_quiet",1,0,0,1,0,4'h0,4'b1000,0,0,0);
    // ring down wrap
    v("rdwrap",1,1,1,1,0,4'h0, 4'b0001,3,1,0);
    v("rd2",   1,1,1,1,0,4'h0, 4'b0010,2,0,0);
    // mode change beats load
    v("mbl",   1,1,0,0,1,4'b0011, 4'b0000,0,0,0);
    // hold and load-beats-en
    v("h1",    1,1,0,0,0,4'h0, 4'b1000,1,0,0);
    v("h2",    1,1,0,0,0,4'h0, 4'b1100,2,0,0);
    v("h3",    1,1,0,0,0,4'h0, 4'b1110,3,0,0);
    for (int i = 0; i < 5; i++)
      v("hold", 1,0,0,0,0,4'h0, 4'b1110,3,0,0);
    v("ldwin", 1,1,0,0,1,4'b0011, 4'b0011,6,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].en, tbl[i].dir,
            tbl[i].mode, tbl[i].load, tbl[i].lv);
      @(posedge clk);
      #1;
      chk(tbl[i].name, obs(),
        {tbl[i].e_out, tbl[i].e_ph, tbl[i].e_wrap, tbl[i].e_err});
    end

    // reset asserted between edges, Johnson: state at 0011 counting up
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 4'h0);
    @(posedge clk); #1;
    chk("pre_rst", obs(), {4'b0001, 3'd7, 1'b0, 1'b0});
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_gap", obs(), {4'b0001, 3'd7, 1'b0, 1'b0});
    @(posedge clk); #1;
    chk("rst_j", obs(), {4'b0000, 3'd0, 1'b0, 1'b0});

    // reset mid-count in ring mode
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 4'h0);
    @(posedge clk); #1;
    chk("r_enter", obs(), {4'b1000, 3'd0, 1'b0, 1'b0});
    @(negedge clk);
    @(posedge clk); #1;
    chk("r_step", obs(), {4'b0100, 3'd1, 1'b0, 1'b0});
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("r_gap", obs(), {4'b0100, 3'd1, 1'b0, 1'b0});
    @(posedge clk); #1;
    chk("rst_r", obs(), {4'b1000, 3'd0, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_counter_gen.md
Name: shift_counter_gen

Overview:
- Parametrised successor to the team's fixed 4-bit Johnson counter.
- WIDTH-bit shift counter, runtime-selectable between Johnson (twisted-ring, 2*WIDTH states) and one-hot ring (WIDTH states) modes.
- Adds up/down direction, count enable, parallel load, a decoded phase index, a wrap pulse, and self-correction of illegal states with an error pulse.
- Used as a phase/sequence generator for multi-phase timing and strobe logic.

Parameters:
- WIDTH, 4, counter width in bits; legal range is WIDTH >= 2.
- PW (derived, not overridable), $clog2(2*WIDTH), width of phase.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled only at the rising edge of clk.
- en  input  1  count enable; 1 = advance one step per clock.
- dir  input  1  0 = up (shift right), 1 = down (shift left).
- mode  input  1  0 = Johnson, 1 = ring.
- load  input  1  1 = load load_val on the next edge.
- load_val  input  WIDTH  parallel load value.
- out  output  WIDTH  registered counter state.
- phase  output  PW  combinational decode of out against the current mode; 0 when out is illegal.
- wrap  output  1  registered one-cycle pulse on a sequence wrap.
- err  output  1  registered one-cycle pulse when an illegal state is corrected.

Behaviour:
- Reset value R(mode): Johnson = all zeros; ring = 1 in bit WIDTH-1, all other bits 0.
- Internal register mode_q holds the mode currently applied to out.
- Next-state priority at each rising edge, highest first:
  1. reset==0: out<=R(mode), mode_q<=mode, wrap<=0, err<=0.
  2. mode!=mode_q: out<=R(mode), mode_q<=mode, wrap<=0, err<=0. Applies regardless of en and load.
  3. load==1: out<=load_val, wrap<=0, err<=0. Load beats en; the loaded value is not checked on this edge.
  4. out illegal for mode_q: out<=R(mode_q), err<=1, wrap<=0. en is ignored on this edge.
  5. en==1: step out, wrap<=1 if the step crosses the wrap boundary, otherwise 0; err<=0.
  6. Otherwise hold out; wrap<=0, err<=0.
- Step rules:
  - Johnson up: {~out[0], out[WIDTH-1:1]}.
  - Johnson down: {out[WIDTH-2:0], ~out[WIDTH-1]}.
  - Ring up: {out[0], out[WIDTH-1:1]}.
  - Ring down: {out[WIDTH-2:0], out[WIDTH-1]}.
- Legal Johnson states (exactly 2*WIDTH):
  - 1^k 0^(WIDTH-k), k = 0..WIDTH, gives phase = k.
  - 0^j 1^(WIDTH-j), j = 1..WIDTH-1, gives phase = WIDTH+j.
- Legal ring states: exactly one bit set. Bit WIDTH-1-k set gives phase = k. All-zero and multi-hot states are illegal.
- Wrap boundary:
  - Up: phase goes from last (2*WIDTH-1 Johnson, WIDTH-1 ring) to 0.
  - Down: phase goes from 0 to last.
  - wrap is high for the single cycle following that edge.
- A dir change takes effect on the next enabled step; there is no bubble.
- Latency: out, wrap and err change one edge after the inputs are sampled; phase follows out combinationally in the same cycle.
- An illegal state is corrected within exactly one edge of becoming visible on out, unless load or a mode change pre-empts the correction.
- Reset mid-operation overrides everything. Reset asserted between edges has no effect until the next rising edge.

Test Plan:
1. WIDTH=4, reset low one edge, then reset=1, en=1, dir=0, mode=0 -> out 0000,1000,1100,1110,1111,0111,0011,0001,0000; phase 0..7 then 0; wrap=1 only in the cycle after the 0001->0000 edge.
2. From 0000, dir=1, en=1 -> out 0001,0011,0111,1111,1110,1100,1000,0000; phase 7,6,...,0; wrap=1 after the first edge (phase 0->7), 0 afterwards.
3. In Johnson at 1100, set mode=1 with en=1 -> next out 1000 with wrap=0; then 0100,0010,0001,1000; phase 0,1,2,3,0; wrap pulses after 0001->1000. Setting mode back to 0 -> out 0000 on the next edge.
4. mode=0, load=1, load_val=1010, en=1 -> out=1010 and phase=0 for one cycle; next edge out=0000 and err=1 for one cycle, with en ignored; counting then resumes 1000... Ring mode with load_val=0000 -> corrected to 1000 with an err pulse.
5. en=0 for 5 clocks at 1110 -> out holds and wrap/err stay 0. load=1 with en=1 and load_val=0011 -> out=0011, phase=6.
6. Reset driven low mid-count, between edges -> out unchanged until the next rising edge, then 0000 (Johnson) or 1000 (ring); wrap=0, err=0.
